// File: rtl/serial_link_pkg.sv
// Shared definitions for the ASCII character link: the transmitter and the receiver both import this package.
package serial_link_pkg;

  localparam int FRAME_BITS_DEFAULT = 10;
  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } link_state_e;

endpackage

// File: rtl/tx_bit_timer.sv
// Modulo-OVERSAMPLE bit-period counter. terminal marks the last clock of the current bit.
module tx_bit_timer #(
  parameter int OVERSAMPLE = serial_link_pkg::OVERSAMPLE_DEFAULT,
  localparam int CW = $clog2(OVERSAMPLE)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          terminal
);

  assign terminal = enable && (count == CW'(OVERSAMPLE - 1));

  // NOTE: sequential state is written only with non-blocking assignments, so every
  // register samples the values from before the edge, whatever the block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= terminal ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/serial_frame_transmitter.sv
// Shifts a pre-framed character out LSB-first, holding each bit for OVERSAMPLE clocks,
// with a polled load / character_sent handshake towards the processor.
module serial_frame_transmitter
  import serial_link_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEFAULT,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  localparam int CW = $clog2(OVERSAMPLE),
  localparam int IW = $clog2(FRAME_BITS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  transmit_enable,
  input  logic [FRAME_BITS-1:0] parallel_in,
  output logic                  data_out,
  output logic                  load,
  output logic                  character_sent,
  output logic                  busy
);

  link_state_e           state;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [IW-1:0]         bit_index;
  logic [CW-1:0]         bit_timer;
  logic                  bit_tick;
  logic                  timer_clear;
  logic                  timer_run;

  // The LOAD cycle is tick 0 of the start bit, so the timer runs from LOAD onwards.
  assign timer_clear = (state == ST_IDLE) || (state == ST_DONE);
  assign timer_run   = (state == ST_LOAD) || (state == ST_SEND);

  tx_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .enable  (timer_run),
    .count   (bit_timer),
    .terminal(bit_tick)
  );

  // data_out is a register mirroring shift_reg[0], so it is updated together with each shift.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      shift_reg      <= '1;
      bit_index      <= '0;
      data_out       <= LINE_IDLE;
      load           <= 1'b0;
      character_sent <= 1'b0;
      busy           <= 1'b0;
    end else begin
      load <= 1'b0;
      case (state)
        ST_IDLE: begin
          data_out <= LINE_IDLE;
          if (transmit_enable) begin
            shift_reg <= parallel_in;
            data_out  <= parallel_in[0];
            bit_index <= '0;
            load      <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state <= ST_SEND;
        end
        ST_SEND: begin
          if (bit_tick) begin
            if (bit_index == IW'(FRAME_BITS - 1)) begin
              shift_reg      <= '1;
              bit_index      <= '0;
              data_out       <= LINE_IDLE;
              busy           <= 1'b0;
              character_sent <= 1'b1;
              state          <= ST_DONE;
            end else begin
              shift_reg <= {1'b1, shift_reg[FRAME_BITS-1:1]};
              data_out  <= shift_reg[1];
              bit_index <= bit_index + IW'(1);
            end
          end
        end
        ST_DONE: begin
          // Holding transmit_enable parks here, so one request never sends twice.
          if (!transmit_enable) begin
            character_sent <= 1'b0;
            state          <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_frame_transmitter.md
Name: serial_frame_transmitter

Overview:
Parallel-to-serial transmitter for the ASCII character link, serving the processor-to-line direction. It takes a 10-bit frame from the processor's parallel output port, which the processor has already framed as start + 8 data + stop. It shifts the frame out LSB-first, holding each bit for OVERSAMPLE cycles of the divided clock. The timing matches the 16x-oversampling receiver at the far end. The load and character_sent outputs give the processor a polled handshake.

Parameters:
FRAME_BITS, 10, bits per frame; bit0 = start (0), bit FRAME_BITS-1 = stop (1)
OVERSAMPLE, 16, clk cycles each bit is held on data_out; must be >= 2

Ports:
clk  input  1  divided system clock, rising-edge
reset_n  input  1  asynchronous, active-low reset
transmit_enable  input  1  processor request to send; level, held until character_sent is seen
parallel_in  input  FRAME_BITS  frame to transmit; sampled only at frame acceptance
data_out  output  1  serial line; idle/mark level 1
load  output  1  1-cycle pulse: frame latched, parallel_in may change
character_sent  output  1  frame complete; held until transmit_enable goes low
busy  output  1  high in LOAD/SEND states

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: data_out=1, load=0, character_sent=0, busy=0, state=IDLE, counters=0, shift register = all 1s.
- Reset mid-frame: data_out returns to 1 immediately (asynchronous). The partial frame is abandoned, with no character_sent.
- States: IDLE, LOAD, SEND, DONE.
- IDLE:
  - data_out=1.
  - If transmit_enable=1 at a rising edge, latch parallel_in into the shift register and go to LOAD.
- LOAD (exactly 1 cycle):
  - load=1, busy=1.
  - data_out = shift_reg[0], i.e. the start bit.
  - bit_timer=0, bit_index=0.
  - Go to SEND.
- SEND:
  - data_out = shift_reg[0].
  - bit_timer counts 0..OVERSAMPLE-1. The LOAD cycle counts as timer tick 0 of bit 0.
  - When bit_timer = OVERSAMPLE-1: shift right with 1 filled in, bit_timer wraps to 0, and bit_index increments.
  - When bit_index = FRAME_BITS-1 and bit_timer = OVERSAMPLE-1, go to DONE.
- Frame timing:
  - Each bit occupies exactly OVERSAMPLE cycles.
  - The whole frame occupies FRAME_BITS*OVERSAMPLE cycles (160 at defaults), starting with the cycle in which load=1.
- DONE:
  - character_sent=1, data_out=1, busy=0.
  - Stays in DONE while transmit_enable=1, so holding enable never causes a resend.
  - Goes to IDLE on the first edge with transmit_enable=0. character_sent is therefore at least a 1-cycle pulse.
- Framing: the frame is sent verbatim, with no check or override of the start/stop bits.
- Latency: if transmit_enable is first seen high at edge k, load and the start bit appear in cycle k+1.
- Simultaneous events:
  - transmit_enable dropping during LOAD/SEND is ignored and the frame completes.
  - parallel_in changes after acceptance have no effect.
- Back-to-back frames: the minimum gap is 1 DONE cycle plus 1 IDLE cycle of idle line (1) between the stop bit and the next start bit.
- Widths: bit_timer is clog2(OVERSAMPLE) bits; bit_index is clog2(FRAME_BITS) bits. Neither counter ever exceeds its terminal value; it wraps or exits explicitly.

Decomposition:
- Shared package serial_link_pkg holds:
  - state encoding (IDLE/LOAD/SEND/DONE)
  - FRAME_BITS and OVERSAMPLE defaults
  - LINE_IDLE=1'b1
- The receiver uses the same package.
- One natural sub-module, tx_bit_timer: modulo-OVERSAMPLE counter with clear and terminal-count output. It feeds the shift/bit_index advance in the parent FSM.

Test Plan:
1. Reset:
   - Stimulus: assert reset_n=0 during the bench's first 5 cycles, with enable=0.
   - Required: data_out=1, load=0, character_sent=0, busy=0. After release, the line stays at 1 for 50 cycles.
2. Single frame:
   - Stimulus: parallel_in=10'b1_0100_0001_0 ('A' framed), enable raised at edge k.
   - Required: load=1 only in cycle k+1. data_out runs 0,1,0,0,0,0,0,1,0,1, each for 16 cycles, from k+1 to k+160. character_sent=1 from cycle k+161.
3. Enable held:
   - Stimulus: keep enable=1 for 400 cycles after a frame.
   - Required: exactly one load pulse. data_out stays 1 after the stop bit. character_sent stays 1.
4. Enable dropped and data changed mid-frame:
   - Stimulus: drop enable and set parallel_in=10'h3FF at cycle k+40.
   - Required: the original 'A' frame completes bit-exact. character_sent is a 1-cycle pulse. The FSM then returns to IDLE.
5. Reset mid-frame:
   - Stimulus: pulse reset_n low at cycle k+70.
   - Required: data_out=1 in the same cycle, no character_sent. A new request then sends a complete frame.
6. Back-to-back frames:
   - Stimulus: frames 10'h3FE then 10'h200, with enable toggled as soon as character_sent is seen.
   - Required: both frames are serialized correctly, separated by at least 2 idle cycles at 1. Exactly two load pulses and two character_sent assertions.
